// File: rtl/db_stream_fetcher_if.sv
// AXI read-address/read-data channels plus the symbol stream of the
// database fetcher, bundled for the master (fetcher) and slave sides.
interface db_stream_fetcher_if #(
    parameter int ADDR_W = 33
);
    logic              axi0_arready_in;
    logic [7:0]        axi0_arid_out;
    logic [ADDR_W-1:0] axi0_araddr_out;
    logic [7:0]        axi0_arlen_out;
    logic              axi0_arvalid_out;
    logic [7:0]        axi0_rid_in;
    logic              axi0_rvalid_in;
    logic [255:0]      axi0_rdata_in;
    logic              axi0_rready_out;
    logic [1:0]        sym_out;
    logic              sym_valid_out;
    logic              sym_ready_in;

    modport master (
        input  axi0_arready_in, axi0_rid_in, axi0_rvalid_in,
        input  axi0_rdata_in, sym_ready_in,
        output axi0_arid_out, axi0_araddr_out, axi0_arlen_out,
        output axi0_arvalid_out, axi0_rready_out,
        output sym_out, sym_valid_out
    );

    modport slave (
        output axi0_arready_in, axi0_rid_in, axi0_rvalid_in,
        output axi0_rdata_in, sym_ready_in,
        input  axi0_arid_out, axi0_araddr_out, axi0_arlen_out,
        input  axi0_arvalid_out, axi0_rready_out,
        input  sym_out, sym_valid_out
    );
endinterface

// File: rtl/db_stream_fetcher.sv
// Fetches a run of 256-bit database beats over AXI, buffers them and
// streams them out as 2-bit nucleotide symbols, LSB first.
module db_stream_fetcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 33,
    parameter int LEN_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [LEN_W-1:0]  num_beats_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    db_stream_fetcher_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = FIFO_DEPTH[CW:0];

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        arid_q, exp_id_q;
    logic [LEN_W-1:0]  len_q, req_q, rcv_q;
    logic [CW-1:0]     out_q, out_d, cnt_q, cnt_d;
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [6:0]        sym_idx_q;
    logic              err_q, done_q;
    logic [255:0]      mem_q [FIFO_DEPTH];

    logic        arvalid, rready, ar_hs, r_hs, sym_hs, pop;
    logic [CW:0] credit;
    logic [255:0] head;

    // Outstanding reads plus buffered beats never exceed the FIFO size,
    // so every returning beat always has a free slot.
    assign credit  = {1'b0, out_q} + {1'b0, cnt_q};
    assign arvalid = (state_q == FETCH) && (req_q < len_q)
                   && (credit < DEPTH_V);
    assign rready  = ((state_q == FETCH) || (state_q == DRAIN))
                   && ((out_q != '0) || arvalid);
    assign ar_hs   = arvalid && bus.axi0_arready_in;
    assign r_hs    = rready && bus.axi0_rvalid_in;
    assign sym_hs  = (cnt_q != '0) && bus.sym_ready_in;
    assign pop     = sym_hs && (sym_idx_q == 7'd127);
    assign head    = mem_q[rptr_q];

    assign bus.axi0_arvalid_out = arvalid;
    assign bus.axi0_araddr_out  = addr_q;
    assign bus.axi0_arid_out    = arid_q;
    assign bus.axi0_arlen_out   = 8'd0;
    assign bus.axi0_rready_out  = rready;
    assign bus.sym_valid_out    = (cnt_q != '0);
    assign bus.sym_out = (cnt_q != '0) ? head[{sym_idx_q, 1'b0} +: 2] : 2'b00;

    assign busy_out = (state_q != IDLE) || start_in;
    assign done_out = done_q;
    assign err_out  = err_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        if (ar_hs && !r_hs) out_d = out_q + CW'(1);
        if (!ar_hs && r_hs) out_d = out_q - CW'(1);
        if (r_hs && !pop)   cnt_d = cnt_q + CW'(1);
        if (!r_hs && pop)   cnt_d = cnt_q - CW'(1);
        unique case (state_q)
            IDLE: begin
                if (start_in)
                    state_d = (num_beats_in == '0) ? DONE : FETCH;
            end
            FETCH: begin
                if (ar_hs && (req_q + LEN_W'(1) == len_q))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if ((rcv_q == len_q) && (cnt_q == '0))
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            arid_q    <= '0;
            exp_id_q  <= '0;
            len_q     <= '0;
            req_q     <= '0;
            rcv_q     <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            sym_idx_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_q == DONE);
            if (r_hs)   wptr_q    <= wptr_q + PW'(1);
            if (pop)    rptr_q    <= rptr_q + PW'(1);
            if (sym_hs) sym_idx_q <= sym_idx_q + 7'd1;
            if ((state_q == IDLE) && start_in) begin
                addr_q   <= base_addr_in;
                len_q    <= num_beats_in;
                req_q    <= '0;
                rcv_q    <= '0;
                arid_q   <= '0;
                exp_id_q <= '0;
                err_q    <= 1'b0;
            end else begin
                if (ar_hs) begin
                    addr_q <= addr_q + ADDR_W'(32);
                    arid_q <= arid_q + 8'd1;
                    req_q  <= req_q + LEN_W'(1);
                end
                if (r_hs) begin
                    rcv_q    <= rcv_q + LEN_W'(1);
                    exp_id_q <= exp_id_q + 8'd1;
                    if (bus.axi0_rid_in != exp_id_q) err_q <= 1'b1;
                end
            end
        end
    end

    // Beat storage needs no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (r_hs) mem_q[wptr_q] <= bus.axi0_rdata_in;
    end
endmodule

// File: tb/tb_db_stream_fetcher.sv
// Randomized bench for db_stream_fetcher: AXI slave model plus a
// reference symbol stream derived from base address and beat contents.
module tb_db_stream_fetcher;
    localparam int ADDR_W = 33;
    localparam int STALL  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_in = 1'b0;
    logic [ADDR_W-1:0] base_addr_in = '0;
    logic [15:0]       num_beats_in = '0;
    logic              busy_out, done_out, err_out;

    db_stream_fetcher_if #(.ADDR_W(ADDR_W)) bus();

    db_stream_fetcher #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W), .LEN_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_in     (start_in),
        .base_addr_in (base_addr_in),
        .num_beats_in (num_beats_in),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .err_out      (err_out),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory image: fixed test-plan words, or a hash of the address.
    function automatic logic [255:0] beat_of(input logic [ADDR_W-1:0] a,
                                             input bit fx);
        logic [255:0] r;
        logic [31:0]  w;
        r = '0;
        if (fx) begin
            if (a == 33'h0)  r = 256'h1910;
            if (a == 33'h20) r = 256'hb808;
        end else begin
            for (int j = 0; j < 8; j++) begin
                w = ((a[31:0] >> 5) + 32'(j)) * 32'h9E3779B1;
                r[32*j +: 32] = w ^ (w >> 15);
            end
        end
        return r;
    endfunction

    typedef struct {
        logic [7:0]   id;
        logic [255:0] data;
    } rbeat_t;

    rbeat_t rq[$];
    bit zl = 0, fixed = 0, rnd_ar = 0, rnd_r = 0, rnd_sym = 0;
    bit hold_sym = 0, bad_first = 0, stall_pending = 0;
    int stall_left = 0;
    logic [ADDR_W-1:0] st_addr;
    logic [7:0]        st_id;

    logic         arready_drv = 1'b1;
    logic         sym_ready_drv = 1'b0;
    logic         q_rvalid = 1'b0;
    logic [7:0]   q_rid = '0;
    logic [255:0] q_rdata = '0;

    assign bus.axi0_arready_in = arready_drv;
    assign bus.axi0_rvalid_in  = zl ? (bus.axi0_arvalid_out && arready_drv)
                                    : q_rvalid;
    assign bus.axi0_rid_in     = zl ? bus.axi0_arid_out : q_rid;
    assign bus.axi0_rdata_in   = zl ? beat_of(bus.axi0_araddr_out, fixed)
                                    : q_rdata;
    assign bus.sym_ready_in    = sym_ready_drv;

    logic [ADDR_W-1:0] m_base = '0;
    int m_n = 0, ar_cnt = 0, r_cnt = 0, sym_cnt = 0;
    int done_cnt = 0, done_cyc = 0, cyc = 0, start_cyc = 0;
    int first_r_cyc = 0, first_v_cyc = 0, first_s_cyc = 0, last_s_cyc = 0;
    bit seen_r = 0, seen_v = 0, seen_s = 0;
    logic [ADDR_W-1:0] ar_log[$];
    logic [1:0]        sym_log[$];

    always @(posedge clk) cyc++;

    // Drive slave/consumer inputs, then score the handshakes that the
    // coming rising edge will perform.
    always @(negedge clk) begin : mon
        logic ar_p, r_p, s_p, rv;
        logic [255:0] bw;
        logic [1:0] e;
        int b, k;
        if (done_out) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rst) begin
            rq.delete();
            q_rvalid = 1'b0;
            arready_drv = 1'b1;
            sym_ready_drv = 1'b0;
        end else begin
            sym_ready_drv = hold_sym ? 1'b0
                          : (rnd_sym ? ($urandom_range(3) != 0) : 1'b1);
            arready_drv = rnd_ar ? 1'($urandom_range(1)) : 1'b1;
            if (stall_left > 0 && bus.axi0_arvalid_out) begin
                arready_drv = 1'b0;
                if (stall_left == STALL) begin
                    st_addr = bus.axi0_araddr_out;
                    st_id   = bus.axi0_arid_out;
                end else begin
                    chk("stall_addr", bus.axi0_araddr_out, st_addr);
                    chk("stall_id", bus.axi0_arid_out, st_id);
                end
                stall_left--;
                stall_pending = (stall_left == 0);
            end else if (stall_pending) begin
                arready_drv = 1'b1;
                stall_pending = 0;
                chk("stall_hs", bus.axi0_arvalid_out, 1);
                chk("stall_addr_hs", bus.axi0_araddr_out, st_addr);
            end
            q_rvalid = !zl && rq.size() > 0
                     && (!rnd_r || $urandom_range(2) != 0);
            if (rq.size() > 0) begin
                q_rid   = rq[0].id;
                q_rdata = rq[0].data;
            end
            ar_p = bus.axi0_arvalid_out && arready_drv;
            rv   = zl ? ar_p : q_rvalid;
            r_p  = rv && bus.axi0_rready_out;
            s_p  = bus.sym_valid_out && sym_ready_drv;
            if (bus.sym_valid_out && !seen_v) begin
                seen_v = 1;
                first_v_cyc = cyc;
            end
            if (r_p) begin
                if (!zl) void'(rq.pop_front());
                if (!seen_r) begin
                    seen_r = 1;
                    first_r_cyc = cyc;
                end
                r_cnt++;
            end
            if (ar_p) begin
                chk("arlen", bus.axi0_arlen_out, 0);
                chk("ar_extra", ar_cnt < m_n, 1);
                chk("araddr", bus.axi0_araddr_out, m_base + 33'(32 * ar_cnt));
                chk("arid", bus.axi0_arid_out, 8'(ar_cnt));
                ar_log.push_back(bus.axi0_araddr_out);
                if (!zl)
                    rq.push_back('{(bad_first && ar_cnt == 0) ? 8'd3
                                   : bus.axi0_arid_out,
                                   beat_of(bus.axi0_araddr_out, fixed)});
                ar_cnt++;
            end
            if (s_p) begin
                if (!seen_s) first_s_cyc = cyc;
                seen_s = 1;
                last_s_cyc = cyc;
                b  = sym_cnt / 128;
                k  = sym_cnt % 128;
                bw = beat_of(m_base + 33'(32 * b), fixed);
                e  = bw[2*k +: 2];
                chk("sym_extra", sym_cnt < m_n * 128, 1);
                chk("sym", bus.sym_out, e);
                sym_log.push_back(bus.sym_out);
                sym_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return {7'b0, busy_out, done_out, err_out, bus.axi0_arvalid_out,
                bus.axi0_rready_out, bus.sym_valid_out, bus.sym_out,
                bus.axi0_arid_out, bus.axi0_araddr_out, bus.axi0_arlen_out};
    endfunction

    function automatic logic [ADDR_W-1:0] logat(input int i);
        return (i < ar_log.size()) ? ar_log[i] : '1;
    endfunction

    function automatic logic [1:0] symat(input int i);
        return (i < sym_log.size()) ? sym_log[i] : 2'b11;
    endfunction

    task automatic start_xfer(input logic [ADDR_W-1:0] b, input int n);
        m_base = b;
        m_n = n;
        ar_cnt = 0;
        r_cnt = 0;
        sym_cnt = 0;
        seen_r = 0;
        seen_v = 0;
        seen_s = 0;
        ar_log.delete();
        sym_log.delete();
        base_addr_in = b;
        num_beats_in = n[15:0];
        start_in = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        chk("busy_start", busy_out, 1);
        step();
        start_in = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int d0 = done_cnt;
        int i = 0;
        while (done_cnt == d0 && i < maxc) begin
            step();
            i++;
        end
        chk("done_timeout", done_cnt != d0, 1);
        repeat (3) step();
        chk("done_once", done_cnt - d0, 1);
    endtask

    task automatic post(input int n);
        chk("ar_n", ar_cnt, n);
        chk("r_n", r_cnt, n);
        chk("sym_n", sym_cnt, n * 128);
        chk("busy_idle", busy_out, 0);
    endtask

    initial begin
        int n, d0, i;
        logic [ADDR_W-1:0] b;
        repeat (3) step();
        chk("reset_outs", outs(), 0);
        rst = 1'b0;
        step();

        zl = 1;
        fixed = 1;
        start_xfer(33'h0, 2);
        wait_done(800);
        post(2);
        chk("zl_ar0", logat(0), 33'h0);
        chk("zl_ar1", logat(1), 33'h20);
        chk("zl_first4", {symat(0), symat(1), symat(2), symat(3)}, 8'b00_00_01_00);
        chk("zl_b1_4", {symat(128), symat(129), symat(130), symat(131)},
            8'b00_10_00_00);
        chk("zl_latency", first_v_cyc - first_r_cyc, 1);
        chk("zl_nogap", last_s_cyc - first_s_cyc, 255);
        zl = 0;
        fixed = 0;

        rnd_r = 1;
        hold_sym = 1;
        start_xfer(33'h1000, 8);
        repeat (40) step();
        chk("bp_ar", ar_cnt, 4);
        chk("bp_arvalid", bus.axi0_arvalid_out, 0);
        chk("bp_sym", sym_cnt, 0);
        hold_sym = 0;
        wait_done(4000);
        post(8);

        rnd_r = 0;
        stall_left = STALL;
        start_xfer(33'h2000, 3);
        wait_done(1500);
        post(3);
        chk("stall_used", stall_left, 0);

        bad_first = 1;
        start_xfer(33'h3000, 2);
        wait_done(1500);
        post(2);
        chk("err_set", err_out, 1);
        repeat (5) step();
        chk("err_hold", err_out, 1);
        bad_first = 0;
        start_xfer(33'h3400, 1);
        chk("err_clr", err_out, 0);
        wait_done(1000);
        post(1);

        start_xfer(33'h500, 0);
        wait_done(20);
        chk("zero_lat", done_cyc - start_cyc, 2);
        chk("zero_ar", ar_cnt, 0);

        hold_sym = 1;
        start_xfer(33'h6000, 6);
        repeat (4) step();
        base_addr_in = 33'h9000;
        num_beats_in = 16'd1;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        repeat (5) step();
        chk("ign_ar", ar_cnt, 4);
        hold_sym = 0;
        wait_done(3000);
        post(6);

        rnd_ar = 1;
        rnd_r = 1;
        rnd_sym = 1;
        for (int t = 0; t < 4; t++) begin
            n = int'($urandom_range(12, 1));
            b = 33'($urandom_range(4095)) << 5;
            start_xfer(b, n);
            wait_done(n * 128 * 8 + 500);
            post(n);
        end

        start_xfer(33'h8000, 10);
        i = 0;
        while (r_cnt < 3 && i < 300) begin
            step();
            i++;
        end
        chk("rst_reach", r_cnt >= 3, 1);
        d0 = done_cnt;
        rst = 1'b1;
        step();
        chk("rst_outs", outs(), 0);
        rst = 1'b0;
        repeat (4) step();
        chk("rst_nodone", done_cnt - d0, 0);
        rnd_ar = 0;
        rnd_r = 0;
        rnd_sym = 0;
        start_xfer(33'h40, 3);
        wait_done(1500);
        post(3);
        chk("rst_ar0", logat(0), 33'h40);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
